// File: rtl/fft_sample_collector.sv
// fft_sample_collector: gathers a serial stream of signed samples into
// 8-sample frames presented in parallel to the FFT calculator. A fill bank
// collects the next frame while the output bank holds the current one.
// Optional sticky overrun detection is built when FFT_COLLECT_OVERRUN_EN is defined.
module fft_sample_collector #(
  parameter int SAMPLE_W = 8
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [SAMPLE_W-1:0] iSample,
  input  logic                iSampleValid,
  output logic                oSampleReady,
  input  logic                iFrameAck,
  output logic [SAMPLE_W-1:0] oSamples0,
  output logic [SAMPLE_W-1:0] oSamples1,
  output logic [SAMPLE_W-1:0] oSamples2,
  output logic [SAMPLE_W-1:0] oSamples3,
  output logic [SAMPLE_W-1:0] oSamples4,
  output logic [SAMPLE_W-1:0] oSamples5,
  output logic [SAMPLE_W-1:0] oSamples6,
  output logic [SAMPLE_W-1:0] oSamples7,
  output logic                oFrameValid,
  output logic [7:0]          oFrameCount,
  output logic                oOverrun,
  input  logic                iOverrunClr
);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  logic [0:0]          r_state;
  logic [SAMPLE_W-1:0] r_fill [8];
  logic [SAMPLE_W-1:0] r_out  [8];
  logic [2:0]          r_wr_idx;
  logic                r_frame_valid;
  logic [7:0]          r_frame_count;

  logic w_ready;
  logic w_accept;
  logic w_out_free;

  // Handshake and output-availability decode
  always_comb begin
    w_ready    = (r_state == ST_FILL);
    w_accept   = iSampleValid && w_ready;
    w_out_free = !r_frame_valid || iFrameAck;
  end

  // Frame assembly, hand-off to the output bank and frame bookkeeping
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state       <= ST_FILL;
      r_wr_idx      <= '0;
      r_frame_valid <= 1'b0;
      r_frame_count <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        r_fill[i] <= '0;
        r_out[i]  <= '0;
      end
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_accept && (r_wr_idx == 3'd7)) begin
            if (w_out_free) begin
              // Last sample bypasses the fill bank straight to slot 7
              for (int unsigned i = 0; i < 7; i++) begin
                r_out[i] <= r_fill[i];
              end
              r_out[7]      <= iSample;
              r_frame_valid <= 1'b1;
              r_frame_count <= r_frame_count + 8'd1;
              r_wr_idx      <= '0;
            end else begin
              r_fill[7] <= iSample;
              r_state   <= ST_FULL;
            end
          end else begin
            if (w_accept) begin
              r_fill[r_wr_idx] <= iSample;
              r_wr_idx         <= r_wr_idx + 3'd1;
            end
            if (iFrameAck && r_frame_valid) begin
              r_frame_valid <= 1'b0;
            end
          end
        end
        ST_FULL: begin
          // Output is always occupied here, so an ack swaps in the held frame
          if (iFrameAck) begin
            for (int unsigned i = 0; i < 8; i++) begin
              r_out[i] <= r_fill[i];
            end
            r_frame_count <= r_frame_count + 8'd1;
            r_wr_idx      <= '0;
            r_state       <= ST_FILL;
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

`ifdef FFT_COLLECT_OVERRUN_EN
  logic r_overrun;

  // Sticky overrun: a sample offered while not ready is lost; set beats clear
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_overrun <= 1'b0;
    end else if (iSampleValid && !w_ready) begin
      r_overrun <= 1'b1;
    end else if (iOverrunClr) begin
      r_overrun <= 1'b0;
    end
  end

  assign oOverrun = r_overrun;
`else
  logic w_unused_ovr_clr;
  assign w_unused_ovr_clr = iOverrunClr;
  assign oOverrun         = 1'b0;
`endif

  assign oSampleReady = w_ready;
  assign oFrameValid  = r_frame_valid;
  assign oFrameCount  = r_frame_count;
  assign oSamples0    = r_out[0];
  assign oSamples1    = r_out[1];
  assign oSamples2    = r_out[2];
  assign oSamples3    = r_out[3];
  assign oSamples4    = r_out[4];
  assign oSamples5    = r_out[5];
  assign oSamples6    = r_out[6];
  assign oSamples7    = r_out[7];

endmodule

// File: tb/tb_fft_sample_collector.sv
// Self-checking bench for fft_sample_collector: directed scenarios with literal
// expectations plus randomized traffic against a queue-based frame model.
module tb_fft_sample_collector;

`ifdef FFT_COLLECT_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] iSample = '0;
  logic       iSampleValid = 1'b0;
  logic       oSampleReady;
  logic       iFrameAck = 1'b0;
  logic [7:0] oSamples0, oSamples1, oSamples2, oSamples3;
  logic [7:0] oSamples4, oSamples5, oSamples6, oSamples7;
  logic       oFrameValid;
  logic [7:0] oFrameCount;
  logic       oOverrun;
  logic       iOverrunClr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  fft_sample_collector #(.SAMPLE_W(8)) dut (
    .Clock(Clock), .Reset(Reset), .iSample(iSample), .iSampleValid(iSampleValid),
    .oSampleReady(oSampleReady), .iFrameAck(iFrameAck),
    .oSamples0(oSamples0), .oSamples1(oSamples1), .oSamples2(oSamples2), .oSamples3(oSamples3),
    .oSamples4(oSamples4), .oSamples5(oSamples5), .oSamples6(oSamples6), .oSamples7(oSamples7),
    .oFrameValid(oFrameValid), .oFrameCount(oFrameCount), .oOverrun(oOverrun),
    .iOverrunClr(iOverrunClr)
  );

  always #5 Clock = ~Clock;

  logic [7:0] d_out [8];
  assign d_out[0] = oSamples0;
  assign d_out[1] = oSamples1;
  assign d_out[2] = oSamples2;
  assign d_out[3] = oSamples3;
  assign d_out[4] = oSamples4;
  assign d_out[5] = oSamples5;
  assign d_out[6] = oSamples6;
  assign d_out[7] = oSamples7;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: partial frame as a queue, one held frame, one presented frame
  logic [7:0] m_fill [$];
  logic [7:0] m_pend [8];
  logic [7:0] m_out  [8];
  bit         m_pending = 0;
  bit         m_valid   = 0;
  logic [7:0] m_count   = '0;
  bit         m_ovr     = 0;

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_fill.delete();
      m_pending = 0;
      m_valid   = 0;
      m_count   = '0;
      m_ovr     = 0;
      for (int i = 0; i < 8; i++) m_out[i] = '0;
    end else begin
      if (OVR_EN) begin
        if (iSampleValid && m_pending) m_ovr = 1;
        else if (iOverrunClr)          m_ovr = 0;
      end
      if (m_pending) begin
        if (iFrameAck) begin
          for (int i = 0; i < 8; i++) m_out[i] = m_pend[i];
          m_count   = m_count + 8'd1;
          m_pending = 0;
        end
      end else begin
        bit completed;
        completed = 0;
        if (iSampleValid) begin
          m_fill.push_back(iSample);
          if (m_fill.size() == 8) begin
            completed = 1;
            if (!m_valid || iFrameAck) begin
              for (int i = 0; i < 8; i++) m_out[i] = m_fill[i];
              m_valid = 1;
              m_count = m_count + 8'd1;
            end else begin
              for (int i = 0; i < 8; i++) m_pend[i] = m_fill[i];
              m_pending = 1;
            end
            m_fill.delete();
          end
        end
        if (!completed && iFrameAck) m_valid = 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge Clock) begin
    chk("ready", oSampleReady, !m_pending);
    chk("frame_valid", oFrameValid, m_valid);
    chk("frame_count", oFrameCount, m_count);
    chk("overrun", oOverrun, m_ovr);
    for (int i = 0; i < 8; i++) chk($sformatf("oSamples%0d", i), d_out[i], m_out[i]);
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic send(input logic [7:0] s, input logic ack);
    iSampleValid = 1'b1;
    iSample      = s;
    iFrameAck    = ack;
    step();
    iSampleValid = 1'b0;
    iFrameAck    = 1'b0;
  endtask

  logic [7:0] f1 [8];

  initial begin
    f1 = '{8'h02, 8'h05, 8'hFE, 8'h00, 8'h01, 8'hFC, 8'h03, 8'h02};

    // Reset with a sample offered: nothing is accepted
    iSampleValid = 1'b1;
    iSample      = 8'h55;
    repeat (3) step();
    chk("rst_valid", oFrameValid, 1'b0);
    chk("rst_count", oFrameCount, 8'd0);
    chk("rst_ready", oSampleReady, 1'b1);
    chk("rst_s0", oSamples0, 8'h00);
    chk("rst_ovr", oOverrun, 1'b0);
    iSampleValid = 1'b0;
    Reset = 1'b0;
    step();

    // Single frame
    for (int k = 0; k < 8; k++) send(f1[k], 1'b0);
    chk("f1_valid", oFrameValid, 1'b1);
    chk("f1_count", oFrameCount, 8'd1);
    chk("f1_s0", oSamples0, 8'h02);
    chk("f1_s2", oSamples2, 8'hFE);
    chk("f1_s5", oSamples5, 8'hFC);
    chk("f1_s7", oSamples7, 8'h02);

    // Backpressure and overrun while FULL
    for (int k = 0; k < 8; k++) send(8'h10 + 8'(k), 1'b0);
    chk("bp_ready", oSampleReady, 1'b0);
    chk("bp_hold_s0", oSamples0, 8'h02);
    chk("bp_count", oFrameCount, 8'd1);
    send(8'h77, 1'b0);
    chk("ovr_set", oOverrun, OVR_EN);
    step();
    chk("ovr_sticky", oOverrun, OVR_EN);
    iOverrunClr = 1'b1;
    step();
    iOverrunClr = 1'b0;
    chk("ovr_clr", oOverrun, 1'b0);
    iFrameAck = 1'b1;
    step();
    iFrameAck = 1'b0;
    chk("f2_s0", oSamples0, 8'h10);
    chk("f2_s7", oSamples7, 8'h17);
    chk("f2_valid", oFrameValid, 1'b1);
    chk("f2_count", oFrameCount, 8'd2);
    chk("f2_ready", oSampleReady, 1'b1);

    // Ack coincident with frame completion
    for (int k = 0; k < 7; k++) send(8'h20 + 8'(k), 1'b0);
    chk("f3_pre_valid", oFrameValid, 1'b1);
    send(8'h27, 1'b1);
    chk("f3_valid", oFrameValid, 1'b1);
    chk("f3_s0", oSamples0, 8'h20);
    chk("f3_s7", oSamples7, 8'h27);
    chk("f3_count", oFrameCount, 8'd3);

    // Plain ack: valid drops, data holds; ack with nothing valid is ignored
    iFrameAck = 1'b1;
    step();
    chk("ack_valid", oFrameValid, 1'b0);
    chk("ack_hold_s3", oSamples3, 8'h23);
    chk("ack_count", oFrameCount, 8'd3);
    step();
    iFrameAck = 1'b0;
    chk("ack_idle_count", oFrameCount, 8'd3);

    // 253 more frames wrap the counter to 0
    for (int f = 0; f < 253; f++)
      for (int k = 0; k < 8; k++) send(8'($urandom), k == 7);
    chk("wrap_count", oFrameCount, 8'd0);
    chk("wrap_valid", oFrameValid, 1'b1);

    // Reset mid-frame discards the partial frame
    for (int k = 0; k < 3; k++) send(8'hAA, 1'b0);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    for (int k = 0; k < 8; k++) send(8'h30 + 8'(k), 1'b0);
    chk("mid_s0", oSamples0, 8'h30);
    chk("mid_s7", oSamples7, 8'h37);
    chk("mid_count", oFrameCount, 8'd1);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 4000; c++) begin
      iSampleValid = ($urandom_range(0, 9) < 7);
      iSample      = 8'($urandom);
      iFrameAck    = ($urandom_range(0, 9) < 3);
      iOverrunClr  = ($urandom_range(0, 19) == 0);
      Reset        = ($urandom_range(0, 599) == 0);
      step();
    end
    Reset        = 1'b0;
    iSampleValid = 1'b0;
    iFrameAck    = 1'b0;
    iOverrunClr  = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_sample_collector.md
Name: fft_sample_collector

Overview:
Upstream stage of the FFT calculator. Accepts a serial stream of signed 8-bit samples over a valid/ready handshake and assembles them into 8-sample frames. Each complete frame is presented as eight parallel words (oSamples0..oSamples7) that feed the calculator's iSamples0..iSamples7 inputs. A second fill buffer collects the next frame while the calculator consumes the current one.

Parameters:
SAMPLE_W, 8, sample width in bits. The frame length is fixed at 8 samples.

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
iSample  input  SAMPLE_W  incoming sample, two's complement
iSampleValid  input  1  iSample is valid this cycle
oSampleReady  output  1  collector can accept a sample this cycle
iFrameAck  input  1  calculator has consumed the presented frame
oSamples0..oSamples7  output  SAMPLE_W each  presented frame; index 0 is the oldest sample
oFrameValid  output  1  oSamples0..7 hold an unconsumed frame
oFrameCount  output  8  number of frames presented, wraps modulo 256
oOverrun  output  1  sticky overrun flag (see Optional Feature)
iOverrunClr  input  1  clears oOverrun

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is asynchronous, active-high.
  - While Reset is high: fill registers, oSamples0..7, oFrameValid, oFrameCount, oOverrun and the write index are all 0, and state is FILL.
  - oSampleReady is combinational: 1 in FILL, 0 in FULL. It therefore reads 1 during reset, but nothing is accepted while Reset is high.
- Accept condition: a sample is accepted when iSampleValid && oSampleReady on a rising edge. The sample is written to fill slot wr_idx, and wr_idx (3 bits) increments.
- State FILL, accept with wr_idx < 7: store the sample, wr_idx+1.
- State FILL, accept with wr_idx == 7, where the output is free (oFrameValid==0, or iFrameAck==1 in the same cycle):
  - Copy fill slots 0..6 plus the current sample into oSamples0..7.
  - oFrameValid=1 on the next cycle.
  - oFrameCount+1, wr_idx=0, stay in FILL.
  - Latency: the 8th accepted sample appears on oSamples7 one cycle after acceptance.
- State FILL, accept with wr_idx == 7, output occupied: store the sample in slot 7 and go to FULL.
- State FULL:
  - oSampleReady=0.
  - On iFrameAck: copy fill to output, oFrameValid stays 1 (new frame), oFrameCount+1, wr_idx=0, return to FILL.
  - oSampleReady rises the cycle after the ack.
- iFrameAck with oFrameValid==1 and no pending transfer: oFrameValid clears next cycle. oSamples0..7 keep their values; they are not cleared.
- iFrameAck with oFrameValid==0: ignored.
- Simultaneous ack and completion of a frame in FILL: the new frame replaces the old one with no bubble, and oFrameValid stays high.
- oFrameCount wraps from 255 to 0.
- Samples are passed through unmodified. There is no sign extension and no arithmetic.
- Reset mid-frame: the partial frame is discarded and wr_idx returns to 0.

Optional Feature:
Macro FFT_COLLECT_OVERRUN_EN.
- Defined:
  - oOverrun is set on any cycle where iSampleValid==1 and oSampleReady==0; the dropped sample is counted as lost.
  - oOverrun stays set until a cycle with iOverrunClr==1.
  - If set and clear occur in the same cycle, set wins.
- Not defined: oOverrun is tied to 0, iOverrunClr is ignored, and no overrun logic is synthesised.

Test Plan:
1. Reset: hold Reset high, drive iSampleValid=1 and iSample=0x55 -> all outputs 0 and oSampleReady=1; release Reset -> the first accepted sample goes to slot 0.
2. Single frame: stream 02,05,FE,00,01,FC,03,02 on consecutive cycles with iFrameAck=0 -> one cycle after the 8th sample, oSamples0..7 = 02,05,FE,00,01,FC,03,02, oFrameValid=1, oFrameCount=1.
3. Backpressure: with frame 1 unacked, stream 8 more samples 10..17 -> oSampleReady falls after the 8th. Pulse iFrameAck -> next cycle oSamples = 10..17, oFrameValid=1, oFrameCount=2; oSampleReady=1 one cycle after the ack.
4. Ack on completion: assert iFrameAck in the same cycle the 8th sample of the next frame is accepted -> oFrameValid never drops and the new frame is presented with no bubble.
5. Plain ack: ack with no pending frame -> oFrameValid=0 next cycle and oSamples hold their last values. Run 256 frames -> oFrameCount wraps to 0.
6. Overrun (FFT_COLLECT_OVERRUN_EN defined): in FULL, drive iSampleValid=1 -> oOverrun=1 next cycle and stays 1; iOverrunClr=1 -> 0. Without the macro -> oOverrun stays 0.
